// File: rtl/guineveer_uart_mon_pkg.sv
// Shared types and constants for the UART receive monitor.
// Holds the receiver FSM state encoding and the frame data width.
package guineveer_uart_mon_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

endpackage

// File: rtl/guineveer_uart_mon_fifo.sv
// Byte FIFO for received UART data; head byte is read straight from the memory flops.
// Push into a full FIFO is accepted only when a pop happens in the same cycle; otherwise it is ignored.
module guineveer_uart_mon_fifo
  import guineveer_uart_mon_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [UART_DATA_BITS-1:0]     data_i,
  input  logic                          pop_i,
  output logic [UART_DATA_BITS-1:0]     data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic                      do_push;
  logic                      do_pop;

  assign full_o  = (count == CNT_W'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  // When full, a simultaneous pop frees the very slot the push writes into.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/guineveer_uart_rx_monitor.sv
// 8N1 UART receiver that samples at bit centres and queues bytes behind a valid/ready port.
// Bytes appear one cycle after the stop sample; a full FIFO with no pop drops the byte and flags overflow.
module guineveer_uart_rx_monitor
  import guineveer_uart_mon_pkg::*;
#(
  parameter int CLKS_PER_BIT = 289,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              rx_i,
  output logic [7:0]                        data_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count_o,
  output logic                              frame_err_o,
  output logic                              overflow_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

  logic                      rx_meta;
  logic                      rx_s;
  logic                      rx_prev;
  uart_rx_state_e            state;
  logic [CNT_W-1:0]          cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      cnt_done;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign cnt_done = (cnt == '0);
  assign push     = (state == STOP) && cnt_done && rx_s;
  assign pop      = valid_o && ready_i;
  assign valid_o  = !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      frame_err_o <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_s) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (!cnt_done) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_s) begin
            bit_idx <= '0;
            cnt     <= FULL_LOAD;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!cnt_done) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg <= {rx_s, shreg[UART_DATA_BITS-1:1]};
            cnt   <= FULL_LOAD;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (!cnt_done) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state <= IDLE;
          end else begin
            frame_err_o <= 1'b1;
            state       <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          // A held-low break stays here so it reports one framing error, not many.
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= push && fifo_full && !pop;
    end
  end

  guineveer_uart_mon_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (shreg),
    .pop_i   (pop),
    .data_o  (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

endmodule
